// File: rtl/zet_rep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zet_rep_sequencer                                            |
// | Description : REP/REPZ/REPNZ string-instruction iteration sequencer:       |
// |               prefix capture, per-pass issue, CX decrement, exit decision. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module zet_rep_sequencer #(
   parameter int CX_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pfx_valid,
   input  logic [7:0]      pfx_byte,
   input  logic            op_start,
   input  logic [7:0]      opcode,
   input  logic [CX_W-1:0] cx_in,
   input  logic            iter_done,
   input  logic            zf,
   input  logic            ext_int,
   input  logic            flush,
   output logic [1:0]      prefix,
   output logic            iter_go,
   output logic [CX_W-1:0] cx_out,
   output logic            cx_we,
   output logic            op_done,
   output logic            int_yield,
   output logic            busy
);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_issue = 3'd1;
   localparam logic [2:0] c_st_wait  = 3'd2;
   localparam logic [2:0] c_st_yield = 3'd3;
   localparam logic [2:0] c_st_done  = 3'd4;

   logic [2:0]      r_state, w_state_nxt;
   logic [1:0]      r_prefix, w_prefix_nxt;
   logic            r_rep, w_rep_nxt;
   logic            r_cmp_sca, w_cmp_sca_nxt;
   logic [1:0]      w_pfx_cur;
   logic            w_is_string;
   logic            w_exit_z;
   logic [CX_W-1:0] w_cx_dec;
   logic            w_unused_op0;

   assign w_unused_op0 = opcode[0];
   assign w_cx_dec     = cx_in - CX_W'(1);
   // REPZ (F3) stops on ZF clear, REPNZ (F2) on ZF set; only CMPS/SCAS look at ZF
   assign w_exit_z     = r_cmp_sca & (r_prefix[0] ? ~zf : zf);
   assign prefix       = r_prefix;
   assign busy         = (r_state != c_st_idle);

   // Prefix as seen this cycle, so a prefix arriving with the opcode still counts
   always_comb begin
      w_pfx_cur = r_prefix;
      if (pfx_valid) begin
         if (pfx_byte == 8'hF3)
            w_pfx_cur = 2'b11;
         else if (pfx_byte == 8'hF2)
            w_pfx_cur = 2'b10;
      end
   end

   always_comb begin
      case (opcode[7:1])
         7'h52, 7'h53, 7'h55, 7'h56, 7'h57, 7'h36, 7'h37: w_is_string = 1'b1;
         default:                                         w_is_string = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_prefix_nxt  = r_prefix;
      w_rep_nxt     = r_rep;
      w_cmp_sca_nxt = r_cmp_sca;
      iter_go       = 1'b0;
      cx_we         = 1'b0;
      cx_out        = '0;
      op_done       = 1'b0;
      int_yield     = 1'b0;
      if (flush) begin
         w_state_nxt  = c_st_idle;
         w_prefix_nxt = 2'b00;
         w_rep_nxt    = 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               w_prefix_nxt = w_pfx_cur;
               if (op_start) begin
                  w_cmp_sca_nxt = opcode[7] & opcode[2] & opcode[1];
                  w_rep_nxt     = w_pfx_cur[1] & w_is_string;
                  if (w_pfx_cur[1] && w_is_string && (cx_in == '0))
                     w_state_nxt = c_st_done;
                  else
                     w_state_nxt = c_st_issue;
               end
            end
            c_st_issue: begin
               iter_go     = 1'b1;
               w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
               if (iter_done) begin
                  if (!r_rep) begin
                     w_state_nxt = c_st_done;
                  end else begin
                     cx_we  = 1'b1;
                     cx_out = w_cx_dec;
                     if ((w_cx_dec == '0) || w_exit_z)
                        w_state_nxt = c_st_done;
                     else if (ext_int)
                        w_state_nxt = c_st_yield;
                     else
                        w_state_nxt = c_st_issue;
                  end
               end
            end
            c_st_yield: begin
               int_yield    = 1'b1;
               w_prefix_nxt = 2'b00;
               w_state_nxt  = c_st_idle;
            end
            c_st_done: begin
               op_done      = 1'b1;
               w_prefix_nxt = 2'b00;
               w_state_nxt  = c_st_idle;
            end
            default: begin
               w_state_nxt  = c_st_idle;
               w_prefix_nxt = 2'b00;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_st_idle;
         r_prefix  <= 2'b00;
         r_rep     <= 1'b0;
         r_cmp_sca <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_prefix  <= w_prefix_nxt;
         r_rep     <= w_rep_nxt;
         r_cmp_sca <= w_cmp_sca_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_zet_rep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_zet_rep_sequencer                                         |
// | Description : Directed self-checking bench for zet_rep_sequencer.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_zet_rep_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pfx_valid = 1'b0;
   logic [7:0]  pfx_byte = 8'h00;
   logic        op_start = 1'b0;
   logic [7:0]  opcode = 8'h00;
   logic [15:0] cx_in = 16'h0;
   logic        iter_done = 1'b0;
   logic        zf = 1'b0;
   logic        ext_int = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  prefix;
   logic        iter_go;
   logic [15:0] cx_out;
   logic        cx_we;
   logic        op_done;
   logic        int_yield;
   logic        busy;

   int n_checks = 0;
   int n_bad    = 0;

   int          res_go, res_we, res_done, res_yield, res_go_cyc, res_done_cyc, res_to;
   logic [15:0] res_hist [8];

   zet_rep_sequencer #(.CX_W(16)) dut (
      .clk(clk), .rst(rst), .pfx_valid(pfx_valid), .pfx_byte(pfx_byte),
      .op_start(op_start), .opcode(opcode), .cx_in(cx_in), .iter_done(iter_done),
      .zf(zf), .ext_int(ext_int), .flush(flush), .prefix(prefix), .iter_go(iter_go),
      .cx_out(cx_out), .cx_we(cx_we), .op_done(op_done), .int_yield(int_yield),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one instruction and plays the exec unit / register file around it.
   // zf_seq/int_seq bit k is what exec reports at the end of iteration k.
   task automatic run_op(input logic [7:0] pfx, input logic [7:0] op, input logic [15:0] cx0,
                         input logic [7:0] zf_seq, input logic [7:0] int_seq, input int flush_at);
      logic [15:0] reg_cx;
      logic        go_now;
      logic        fin;
      int          idx;
      res_go = 0; res_we = 0; res_done = 0; res_yield = 0;
      res_go_cyc = -1; res_done_cyc = -1; res_to = 1;
      for (int k = 0; k < 8; k++) res_hist[k] = 16'hDEAD;
      reg_cx = cx0;
      fin    = 1'b0;
      if (pfx != 8'h00) begin
         pfx_valid = 1'b1;
         pfx_byte  = pfx;
         step();
         pfx_valid = 1'b0;
      end
      op_start = 1'b1;
      opcode   = op;
      cx_in    = cx0;
      flush    = (flush_at == 0);
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (iter_go) begin
            res_go++;
            if (res_go_cyc < 0) res_go_cyc = cyc;
         end
         if (cx_we) begin
            if (res_we < 8) res_hist[res_we] = cx_out;
            res_we++;
            reg_cx = cx_out;
         end
         if (op_done) begin
            res_done++;
            res_done_cyc = cyc;
            fin = 1'b1;
         end
         if (int_yield) begin
            res_yield++;
            fin = 1'b1;
         end
         if (flush_at >= 0 && cyc > flush_at && !busy) fin = 1'b1;
         go_now = iter_go;
         step();
         op_start  = 1'b0;
         pfx_valid = 1'b0;
         idx       = (res_go > 8) ? 7 : res_go - 1;
         iter_done = go_now;
         zf        = go_now ? zf_seq[idx] : 1'b0;
         ext_int   = go_now ? int_seq[idx] : 1'b0;
         cx_in     = reg_cx;
         flush     = (cyc + 1 == flush_at);
         if (fin) begin
            res_to = 0;
            break;
         end
      end
      iter_done = 1'b0; zf = 1'b0; ext_int = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({prefix, iter_go, cx_out, cx_we, op_done, int_yield, busy} !== 23'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got prefix=%b go=%b cx=%h we=%b done=%b yld=%b busy=%b want all 0",
                  prefix, iter_go, cx_out, cx_we, op_done, int_yield, busy);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_prefix();
      pfx_valid = 1'b1; pfx_byte = 8'hF3; step();
      pfx_byte = 8'hF2; step();
      pfx_byte = 8'h26; step();
      pfx_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (prefix !== 2'b10) begin
         n_bad++; $display("FAIL prefix_last_wins: got %b want 10", prefix);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL prefix_idle: busy got %b want 0", busy);
      end
      step();
      flush = 1'b1; step(); flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if (prefix !== 2'b00) begin
         n_bad++; $display("FAIL prefix_flush_clear: got %b want 00", prefix);
      end
      step();
   endtask

   task automatic test_rep_movs();
      run_op(8'hF3, 8'hA5, 16'd3, 8'h00, 8'h00, -1);
      n_checks++;
      if (res_to !== 0) begin n_bad++; $display("FAIL movs_timeout: got %0d want 0", res_to); end
      n_checks++;
      if (res_go !== 3) begin n_bad++; $display("FAIL movs_iter_go: got %0d want 3", res_go); end
      n_checks++;
      if (res_go_cyc !== 1) begin n_bad++; $display("FAIL movs_go_latency: got %0d want 1", res_go_cyc); end
      n_checks++;
      if (res_we !== 3 || res_hist[0] !== 16'd2 || res_hist[1] !== 16'd1 || res_hist[2] !== 16'd0) begin
         n_bad++;
         $display("FAIL movs_cx_seq: got n=%0d %0d,%0d,%0d want n=3 2,1,0",
                  res_we, res_hist[0], res_hist[1], res_hist[2]);
      end
      n_checks++;
      if (res_done !== 1 || res_yield !== 0) begin
         n_bad++; $display("FAIL movs_done: got done=%0d yield=%0d want 1/0", res_done, res_yield);
      end
      @(negedge clk);
      n_checks++;
      if (prefix !== 2'b00 || busy !== 1'b0) begin
         n_bad++; $display("FAIL movs_after: got prefix=%b busy=%b want 00/0", prefix, busy);
      end
      step();
   endtask

   task automatic test_cx_zero();
      run_op(8'hF3, 8'hA5, 16'd0, 8'h00, 8'h00, -1);
      n_checks++;
      if (res_go !== 0 || res_we !== 0) begin
         n_bad++; $display("FAIL cx0_no_work: got go=%0d we=%0d want 0/0", res_go, res_we);
      end
      n_checks++;
      if (res_done !== 1 || res_done_cyc !== 1) begin
         n_bad++; $display("FAIL cx0_done: got done=%0d at cyc %0d want 1 at cyc 1", res_done, res_done_cyc);
      end
   endtask

   task automatic test_repz_cmps();
      // iteration 0 ZF=1 keeps going, iteration 1 ZF=0 ends REPZ
      run_op(8'hF3, 8'hA6, 16'd5, 8'b0000_0001, 8'h00, -1);
      n_checks++;
      if (res_go !== 2 || res_we !== 2 || res_hist[1] !== 16'd3) begin
         n_bad++; $display("FAIL repz_cmps: got go=%0d we=%0d cx=%0d want 2/2/3", res_go, res_we, res_hist[1]);
      end
      n_checks++;
      if (res_done !== 1) begin n_bad++; $display("FAIL repz_cmps_done: got %0d want 1", res_done); end
   endtask

   task automatic test_repnz_scas();
      run_op(8'hF2, 8'hAE, 16'd5, 8'hFF, 8'h00, -1);
      n_checks++;
      if (res_go !== 1 || res_we !== 1 || res_hist[0] !== 16'd4 || res_done !== 1) begin
         n_bad++;
         $display("FAIL repnz_scas: got go=%0d we=%0d cx=%0d done=%0d want 1/1/4/1",
                  res_go, res_we, res_hist[0], res_done);
      end
      run_op(8'hF2, 8'hAA, 16'd5, 8'hFF, 8'h00, -1);
      n_checks++;
      if (res_go !== 5 || res_we !== 5 || res_hist[4] !== 16'd0 || res_done !== 1) begin
         n_bad++;
         $display("FAIL repnz_stos_no_zf: got go=%0d we=%0d cx=%0d done=%0d want 5/5/0/1",
                  res_go, res_we, res_hist[4], res_done);
      end
   endtask

   task automatic test_int_yield();
      run_op(8'hF3, 8'hAB, 16'd4, 8'h00, 8'h01, -1);
      n_checks++;
      if (res_go !== 1 || res_we !== 1 || res_hist[0] !== 16'd3) begin
         n_bad++; $display("FAIL yield_cx: got go=%0d we=%0d cx=%0d want 1/1/3", res_go, res_we, res_hist[0]);
      end
      n_checks++;
      if (res_yield !== 1 || res_done !== 0) begin
         n_bad++; $display("FAIL yield_pulse: got yield=%0d done=%0d want 1/0", res_yield, res_done);
      end
      @(negedge clk);
      n_checks++;
      if (prefix !== 2'b00 || busy !== 1'b0) begin
         n_bad++; $display("FAIL yield_after: got prefix=%b busy=%b want 00/0", prefix, busy);
      end
      step();
   endtask

   task automatic test_single_and_flush();
      run_op(8'h00, 8'h90, 16'd7, 8'h00, 8'h00, -1);
      n_checks++;
      if (res_go !== 1 || res_we !== 0 || res_done !== 1) begin
         n_bad++; $display("FAIL single_pass: got go=%0d we=%0d done=%0d want 1/0/1", res_go, res_we, res_done);
      end
      // flush lands in WAIT together with iter_done of a rep op
      run_op(8'hF3, 8'hA5, 16'd5, 8'h00, 8'h00, 2);
      n_checks++;
      if (res_go !== 1 || res_we !== 0 || res_done !== 0 || res_yield !== 0 || res_to !== 0) begin
         n_bad++;
         $display("FAIL flush_wait: got go=%0d we=%0d done=%0d yield=%0d to=%0d want 1/0/0/0/0",
                  res_go, res_we, res_done, res_yield, res_to);
      end
      @(negedge clk);
      n_checks++;
      if (prefix !== 2'b00) begin n_bad++; $display("FAIL flush_prefix: got %b want 00", prefix); end
      step();
   endtask

   task automatic test_busy_ignore_and_async_reset();
      pfx_valid = 1'b1; pfx_byte = 8'hF3; step();
      pfx_valid = 1'b0;
      op_start = 1'b1; opcode = 8'hA5; cx_in = 16'd5; step();
      opcode = 8'h90; step();
      op_start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || prefix !== 2'b11) begin
         n_bad++; $display("FAIL busy_wait: got busy=%b prefix=%b want 1/11", busy, prefix);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || prefix !== 2'b00) begin
         n_bad++; $display("FAIL async_reset: got busy=%b prefix=%b want 0/00", busy, prefix);
      end
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_prefix();
      test_rep_movs();
      test_cx_zero();
      test_repz_cmps();
      test_repnz_scas();
      test_int_yield();
      test_single_and_flush();
      test_busy_ignore_and_async_reset();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
